inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with a FIFO prefetch buffer.
//
// The PC register drives the instruction ROM. Each accepted fetch pushes
// {pc, rom_inst} into the buffer, whose head is presented to decode.
// A redirect flushes the buffer and reloads the PC, aligned to a 4-byte word.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  number of prefetch buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   stall                    hold fetch (PC frozen, no push)
//   redirect_valid/_pc       flush the buffer and load a new PC
//   rom_ce, rom_addr         ROM chip enable (registered) and byte address (= PC)
//   rom_inst                 ROM read data, valid in the same cycle
//   if_valid/if_pc/if_inst   head-of-buffer entry presented to decode
//   id_ready                 decode accepts the head this cycle
//   fetch_full_cnt           only when FETCH_PERF_EN is defined: count of
//                            fetches blocked by a full buffer
//
// Optional feature macro: FETCH_PERF_EN
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_full_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0]      pc_q, pc_d;
    logic             rom_ce_q, rom_ce_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [FIFO_DEPTH];

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;
    logic unused_redirect_lsb_c;

    // Low address bits of the redirect target are dropped by word alignment.
    assign unused_redirect_lsb_c = ^redirect_pc[1:0];

    // Push/pop qualification; redirect suppresses both.
    always_comb begin
        full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c = (count_q == '0);
        pop_c   = !empty_c && id_ready && !redirect_valid;
        push_c  = rom_ce_q && !stall && !redirect_valid && (!full_c || pop_c);
    end

    // Next-state for PC, pointers and occupancy.
    always_comb begin
        pc_d     = pc_q;
        rom_ce_d = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset clears occupancy asynchronously so if_valid drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rom_ce_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rom_ce_q <= rom_ce_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage carries no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: pc_q, inst: rom_inst};
        end
    end

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q;
    assign if_valid = !empty_c;
    assign if_pc    = mem_q[rd_ptr_q].pc;
    assign if_inst  = mem_q[rd_ptr_q].inst;

`ifdef FETCH_PERF_EN
    logic [31:0] full_cnt_q, full_cnt_d;

    // Count fetch attempts blocked by a full buffer with no drain.
    always_comb begin
        full_cnt_d = full_cnt_q;
        if (rom_ce_q && !stall && !redirect_valid && full_c && !pop_c) begin
            full_cnt_d = full_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_cnt_q <= '0;
        end else begin
            full_cnt_q <= full_cnt_d;
        end
    end

    assign fetch_full_cnt = full_cnt_q;
`endif

endmodule
